// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared operation and state types for the HI/LO multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    function automatic logic op_is_signed(input muldiv_op_t op);
        return !op[0];
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - radix-2 iterative multiply/divide datapath with sign fix-up
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               run_i,
    input  muldiv_op_t         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               finish_o
);
    localparam int CW = $clog2(WIDTH);

    logic               div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH-1:0]   d_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] p_d;
    logic [WIDTH-1:0]   quo, rem;

    assign a_neg = op_is_signed(op_i) & a_i[WIDTH-1];
    assign b_neg = op_is_signed(op_i) & b_i[WIDTH-1];
    assign a_abs = a_neg ? -a_i : a_i;
    assign b_abs = b_neg ? -b_i : b_i;

    // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{p_q[0]}} & d_q};
        shifted = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        ge      = shifted >= {1'b0, d_q};
        diff    = shifted[WIDTH-1:0] - d_q;
        if (div_q) begin
            p_d = {ge ? diff : shifted[WIDTH-1:0], p_q[WIDTH-2:0], ge};
        end else begin
            p_d = {sum, p_q[WIDTH-1:1]};
        end
        quo = p_d[WIDTH-1:0];
        rem = p_d[2*WIDTH-1:WIDTH];
        if (div_q) begin
            result_o = {neg_hi_q ? -rem : rem, neg_lo_q ? -quo : quo};
        end else begin
            result_o = neg_lo_q ? -p_d : p_d;
        end
    end

    assign finish_o = run_i && (cnt_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            d_q      <= '0;
        end else if (load_i) begin
            div_q    <= op_is_div(op_i);
            cnt_q    <= CW'(WIDTH - 1);
            // A zero divisor keeps the quotient all ones and the remainder equal to op_a
            neg_lo_q <= (a_neg ^ b_neg) && !(op_is_div(op_i) && (b_i == '0));
            neg_hi_q <= a_neg;
            if (op_is_div(op_i)) begin
                p_q <= {{WIDTH{1'b0}}, a_abs};
                d_q <= b_abs;
            end else begin
                p_q <= {{WIDTH{1'b0}}, b_abs};
                d_q <= a_abs;
            end
        end else if (run_i) begin
            p_q   <= p_d;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register file with start/kill handshake around the iterative mul/div core
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             kill,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] hi_data,
    input  logic [WIDTH-1:0] lo_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    md_state_t          state_q;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic               done_q;
    logic               mask_hi_q, mask_lo_q;
    logic               accept, run, finish;
    logic [2*WIDTH-1:0] result;

    assign accept = start && (state_q == MD_IDLE) && !kill;
    assign run    = (state_q == MD_RUN) && !kill;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load_i   (accept),
        .run_i    (run),
        .op_i     (op),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (result),
        .finish_o (finish)
    );

    // Direct writes take priority over a result landing on the same edge
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_write) begin
            hi_d = hi_data;
        end else if (finish && !mask_hi_q) begin
            hi_d = result[2*WIDTH-1:WIDTH];
        end
        if (lo_write) begin
            lo_d = lo_data;
        end else if (finish && !mask_lo_q) begin
            lo_d = result[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            mask_hi_q <= 1'b0;
            mask_lo_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= finish;
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        state_q   <= MD_RUN;
                        mask_hi_q <= 1'b0;
                        mask_lo_q <= 1'b0;
                    end
                end
                MD_RUN: begin
                    if (hi_write) mask_hi_q <= 1'b1;
                    if (lo_write) mask_lo_q <= 1'b1;
                    if (kill || finish) state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == MD_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - table-driven and scoreboard checks of hilo_muldiv at WIDTH=32
module tb_hilo_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    muldiv_op_t   op = OP_MULT;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         kill = 1'b0;
    logic         hi_write = 1'b0, lo_write = 1'b0;
    logic [W-1:0] hi_data = '0, lo_data = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
        .kill(kill), .hi_write(hi_write), .lo_write(lo_write), .hi_data(hi_data),
        .lo_data(lo_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        muldiv_op_t   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t sb[$];
    vec_t vecs[12];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input muldiv_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint sa, sb_, ua, ub;
        logic [63:0] p, q, m;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r.hi = '0;
        r.lo = '0;
        case (o)
            OP_MULT:  begin p = sa * sb_; r.hi = p[63:32]; r.lo = p[31:0]; end
            OP_MULTU: begin p = ua * ub;  r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    r.hi = a;
                    r.lo = '1;
                end else begin
                    if (o == OP_DIV) begin q = sa / sb_; m = sa % sb_; end
                    else begin q = ua / ub; m = ua % ub; end
                    r.hi = m[31:0];
                    r.lo = q[31:0];
                end
            end
        endcase
        return r;
    endfunction

    task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el);
        res_t e;
        e.hi = eh;
        e.lo = el;
        sb.push_back(e);
    endtask

    task automatic await_result(input string name, input int exp_lat);
        int cyc = 0;
        int bcnt = 0;
        res_t e;
        while (!done && cyc < 3 * W) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        check({name, " latency"}, cyc, exp_lat);
        check({name, " busy cycles"}, bcnt, exp_lat);
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL %s scoreboard: got 0 entries expected 1", name);
        end else begin
            e = sb.pop_front();
            check({name, " hi"}, hi, e.hi);
            check({name, " lo"}, lo, e.lo);
        end
    endtask

    task automatic run_op(input string name, input muldiv_op_t o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        op = o;
        op_a = a;
        op_b = b;
        start = 1'b1;
        push_exp(eh, el);
        tick();
        start = 1'b0;
        check({name, " accept busy/done"}, {busy, done}, 2'b10);
        await_result(name, W);
    endtask

    initial begin
        res_t m;
        muldiv_op_t ro;
        logic [W-1:0] ra, rb;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[11] = '{OP_MULTU, 32'h12345678, 32'd0,        32'd0,        32'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        reset = 1'b0;
        tick();

        // Consecutive calls start in the done cycle, exercising back-to-back throughput
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

        for (int i = 0; i < 8; i++) begin
            ro = muldiv_op_t'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            m = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, m.hi, m.lo);
        end

        // Direct HI write mid-operation masks the result's upper half
        op = OP_MULTU; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        push_exp(32'hA5, 32'd6);
        tick();
        start = 1'b0;
        repeat (9) tick();
        hi_write = 1'b1; hi_data = 32'hA5;
        tick();
        hi_write = 1'b0;
        check("mask hi visible", hi, 32'hA5);
        await_result("mask hi", W - 10);

        // Direct LO write on the completion edge itself wins
        op = OP_MULTU; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        push_exp(32'd0, 32'h55);
        tick();
        start = 1'b0;
        repeat (W - 1) tick();
        lo_write = 1'b1; lo_data = 32'h55;
        tick();
        lo_write = 1'b0;
        await_result("mask lo at finish", 0);

        run_op("mask cleared", OP_MULTU, 32'h10, 32'h10, 32'd0, 32'h100);

        kill = 1'b1; start = 1'b1; op = OP_MULT;
        tick();
        kill = 1'b0; start = 1'b0;
        check("kill idle blocks start", busy, 0);

        hi_write = 1'b1; hi_data = 32'd1; lo_write = 1'b1; lo_data = 32'd2;
        tick();
        hi_write = 1'b0; lo_write = 1'b0;
        check("preload hi", hi, 32'd1);
        check("preload lo", lo, 32'd2);

        // Killed DIVU while a second request is held on start
        op = OP_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        tick();
        op_a = 32'd9; op_b = 32'd2;
        repeat (4) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy/done", {busy, done}, 2'b00);
        check("kill hi", hi, 32'd1);
        check("kill lo", lo, 32'd2);
        push_exp(32'd1, 32'd4);
        tick();
        start = 1'b0;
        check("held start accepted", busy, 1);
        await_result("held start", W);

        op = OP_MULT; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        #2 reset = 1'b1;
        #1;
        check("async reset hi", hi, 0);
        check("async reset lo", lo, 0);
        check("async reset busy", busy, 0);
        check("async reset done", done, 0);
        #2 reset = 1'b0;
        tick();
        run_op("after reset", OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'd0, 32'd24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO register file with an integrated iterative multiply/divide engine. It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles, writes the double-width result into HI/LO, and accepts direct MTHI/MTLO writes at any time. It sits in the execute stage. The pipeline stalls on `busy` and flushes in-flight operations with `kill`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4 and even.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request a new mul/div operation this cycle.
- `op` in `muldiv_op_t` (2): operation type, sampled with `start`.
- `op_a`, `op_b` in `WIDTH`: multiplicand/dividend and multiplier/divisor, sampled with `start`.
- `kill` in 1: abort the in-flight operation and block any `start` in the same cycle.
- `hi_write`, `lo_write` in 1: direct write enables.
- `hi_data`, `lo_data` in `WIDTH`: direct write data.
- `hi`, `lo` out `WIDTH`: registered HI/LO contents.
- `busy` out 1: operation in flight; new starts are ignored.
- `done` out 1: one-cycle pulse, high in the first cycle that a result is visible on `hi`/`lo`.

## Operation
- **States:** IDLE and RUN. A step counter counts WIDTH-1 down to 0.
- **Accept:** a start is accepted on an edge where `start && !busy && !kill`.
  - `op`, `|op_a|`, `|op_b|` and the result-sign flags are latched.
  - The counter is loaded with WIDTH-1 and the block enters RUN.
  - In unsigned ops, the absolute value is the operand itself.
- **RUN step:** one radix-2 step per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
- **Completion:** on the RUN edge where the counter is 0:
  - Apply the sign fix-up to the 2·WIDTH result.
  - Write HI/LO, subject to the per-half masks described below.
  - Return to IDLE.
- **Multiply result:** the full 2·WIDTH product; HI = upper half, LO = lower half.
- **Divide result:** LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
- **Signed overflow:** DIV of the minimum negative value by −1 gives LO = the minimum negative value and HI = 0.
- **Divide by zero (DIV or DIVU):** HI = `op_a` as sampled, LO = all ones. The operation still takes the full latency.
- **Direct writes:** `hi_write`/`lo_write` update the corresponding register on the same edge in any state.
  - A direct write while `busy`, or on the completion edge itself, sets a sticky mask bit for that half.
  - The pending result does not overwrite a masked half; the later direct write wins.
  - Mask bits clear on accept.
- **kill:** in RUN, return to IDLE on the next edge. HI/LO are unchanged and no `done` pulse follows. Direct writes in the same cycle still apply.
- **Reset:**
  - `hi`, `lo` = 0.
  - `busy`, `done` = 0.
  - State = IDLE; masks cleared.
  - Reset mid-operation discards the operation.

## Timing
- Latency is fixed at WIDTH cycles.
- Let edge 0 be the accept edge:
  - `busy` is high from after edge 0 through edge WIDTH.
  - HI/LO update on edge WIDTH.
  - `done` is high, and `busy` low, in the cycle after edge WIDTH.
- Throughput: a new `start` may be accepted in the same cycle that `done` is high, giving back-to-back operations every WIDTH+1 cycles.
- `start` while `busy`: ignored with no side effect. The requester must hold `start` until it observes `!busy`.
- Direct writes have 1-cycle latency: the value is visible on `hi`/`lo` the cycle after the write. There is no combinational bypass.
- `kill` asserted in IDLE has no effect other than suppressing a same-cycle `start`.

## Structure
- **Package `muldiv_pkg`:**
  - `muldiv_op_t` enum: `OP_MULT` = 0, `OP_MULTU` = 1, `OP_DIV` = 2, `OP_DIVU` = 3.
  - The state enum (`MD_IDLE`, `MD_RUN`).
- **Sub-module `muldiv_core`:** iterative datapath containing the operand/partial registers, counter, and step/sign fix-up logic. It exposes `result[2·WIDTH-1:0]` and a `finish` strobe.
- **Top `hilo_muldiv`:** owns the FSM handshake, the HI/LO registers, masks, `done` and `kill`.

## Test plan
All scenarios use WIDTH = 32.
1. MULTU `0xFFFFFFFF` × `0xFFFFFFFF` → after 32 cycles HI = `0xFFFFFFFE`, LO = `0x00000001`, `done` pulses once, `busy` high for exactly 32 cycles.
2. MULT −3 × 5 → HI = `0xFFFFFFFF`, LO = `0xFFFFFFF1`. Then DIV −7 / 2 → LO = `0xFFFFFFFD`, HI = `0xFFFFFFFF`.
3. DIV `0x80000000` / `0xFFFFFFFF` → LO = `0x80000000`, HI = 0. DIVU 7 / 0 → HI = 7, LO = `0xFFFFFFFF`.
4. MULTU 2 × 3 with `hi_write` `0xA5` at cycle 10 → HI = `0xA5` from cycle 11 and still `0xA5` after completion; LO = 6.
5. `kill` at cycle 5 of a DIVU with HI/LO preloaded to 1/2 → `busy` low next cycle, no `done`, HI/LO stay 1/2. `start` held during `busy` is accepted only when `busy` drops.
6. `reset` at cycle 17 of a MULT → `hi`, `lo`, `busy`, `done` all 0 immediately (asynchronous). The first `start` after release completes normally in 32 cycles.
